// File: rtl/serial_bus_pkg.sv
// Shared serial-bus definitions: width defaults, phase/direction encodings and
// the target port state type.
package serial_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic MODE_ADDR = 1'b1;
    localparam logic MODE_DATA = 1'b0;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_SEL   = 3'd2,
        ST_WDATA = 3'd3,
        ST_WACK  = 3'd4,
        ST_RWAIT = 3'd5,
        ST_RSEND = 3'd6,
        ST_ACK   = 3'd7
    } target_port_state_t;

endpackage

// File: rtl/target_port_if.sv
// Serial-bus side of a target port: initiator stream, decoder select and the
// target's serial response/status lines.
interface target_port_if;

    logic bus_data_in;
    logic bus_data_in_valid;
    logic bus_mode;
    logic bus_rw;
    logic decoder_valid;
    logic bus_data_out;
    logic bus_data_out_valid;
    logic bus_target_ready;
    logic bus_target_rw;
    logic bus_target_ack;

    modport master (
        output bus_data_in, bus_data_in_valid, bus_mode, bus_rw, decoder_valid,
        input  bus_data_out, bus_data_out_valid, bus_target_ready, bus_target_rw, bus_target_ack
    );

    modport slave (
        input  bus_data_in, bus_data_in_valid, bus_mode, bus_rw, decoder_valid,
        output bus_data_out, bus_data_out_valid, bus_target_ready, bus_target_rw, bus_target_ack
    );

endinterface

// File: rtl/serial_deserializer.sv
// LSB-first deserializer with a run-time length; data_o/done_o already include
// the bit presented this cycle so the caller can register the full word at once.
module serial_deserializer #(
    parameter int WIDTH = 16,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [CW-1:0]    len_i,
    output logic [WIDTH-1:0] data_o,
    output logic             done_o
);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    idx_s;
    logic [WIDTH-1:0] base_s;
    logic [WIDTH-1:0] mask_s;

    // Merge the incoming bit at its position; start_i treats it as bit 0 of a fresh word.
    always_comb begin
        idx_s  = start_i ? {CW{1'b0}} : cnt_q;
        base_s = start_i ? {WIDTH{1'b0}} : shreg_q;
        mask_s = en_i ? (WIDTH'(1'b1) << idx_s) : {WIDTH{1'b0}};
        data_o = (base_s & ~mask_s) | (bit_i ? mask_s : {WIDTH{1'b0}});
        done_o = en_i && (idx_s == (len_i - CW'(1)));
        if (done_o) begin
            shreg_d = {WIDTH{1'b0}};
            cnt_d   = {CW{1'b0}};
        end else if (en_i) begin
            shreg_d = data_o;
            cnt_d   = idx_s + CW'(1);
        end else begin
            shreg_d = shreg_q;
            cnt_d   = cnt_q;
        end
    end

    // Shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/target_port.sv
// Non-split serial-bus target port: deserializes address/write data, issues a
// parallel request to a fixed-latency core and serializes read data back.
module target_port
    import serial_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SEL_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    target_port_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] target_addr_in,
    output logic                  target_addr_in_valid,
    output logic [DATA_WIDTH-1:0] target_data_in,
    output logic                  target_data_in_valid,
    output logic                  target_rw,
    input  logic [DATA_WIDTH-1:0] target_data_out,
    input  logic                  target_data_out_valid,
    input  logic                  target_ack,
    input  logic                  target_ready
);

    localparam int DES_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int DES_CW = $clog2(DES_W + 1);
    localparam int SEL_W  = $clog2(SEL_TIMEOUT + 1);
    localparam int BC_W   = $clog2(DATA_WIDTH + 1);
    localparam logic [DES_CW-1:0] ADDR_LEN = DES_CW'(ADDR_WIDTH);
    localparam logic [DES_CW-1:0] DATA_LEN = DES_CW'(DATA_WIDTH);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(SEL_TIMEOUT - 1);
    localparam logic [BC_W-1:0]   BIT_LAST = BC_W'(DATA_WIDTH);

    target_port_state_t    state_q, state_d;
    logic [SEL_W-1:0]      sel_cnt_q, sel_cnt_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  addr_vld_q, addr_vld_d;
    logic                  data_vld_q, data_vld_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  dout_q, dout_d;
    logic                  dout_vld_q, dout_vld_d;
    logic                  ack_q, ack_d;
    logic                  ready_q, ready_d;

    logic                  addr_bit_s, data_bit_s, data_phase_s, addr_done_s;
    logic                  des_en_s, des_start_s, des_done_s;
    logic [DES_CW-1:0]     des_len_s;
    logic [DES_W-1:0]      des_data_s;

    serial_deserializer #(.WIDTH(DES_W)) u_des (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_i   (bus.bus_data_in),
        .en_i    (des_en_s),
        .start_i (des_start_s),
        .len_i   (des_len_s),
        .data_o  (des_data_s),
        .done_o  (des_done_s)
    );

    // Next-state and output decode; an address-mode bit in WDATA restarts capture.
    always_comb begin
        addr_bit_s   = bus.bus_data_in_valid && (bus.bus_mode == MODE_ADDR);
        data_bit_s   = bus.bus_data_in_valid && (bus.bus_mode == MODE_DATA);
        des_start_s  = addr_bit_s && ((state_q == ST_IDLE) || (state_q == ST_WDATA));
        data_phase_s = (state_q == ST_WDATA) && data_bit_s;
        des_en_s     = des_start_s || data_phase_s ||
                       ((state_q == ST_ADDR) && bus.bus_data_in_valid);
        des_len_s    = data_phase_s ? DATA_LEN : ADDR_LEN;
        addr_done_s  = des_done_s && !data_phase_s;

        state_d    = state_q;
        sel_cnt_d  = sel_cnt_q;
        rw_d       = addr_done_s ? bus.bus_rw : rw_q;
        addr_d     = addr_done_s ? des_data_s[ADDR_WIDTH-1:0] : addr_q;
        data_d     = data_q;
        addr_vld_d = 1'b0;
        data_vld_d = 1'b0;
        rdata_d    = rdata_q;
        bit_cnt_d  = bit_cnt_q;
        dout_d     = 1'b0;
        dout_vld_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (des_start_s) begin
                    state_d = des_done_s ? ST_SEL : ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_d = des_done_s ? ST_SEL : ST_ADDR;
            end
            ST_SEL: begin
                if (bus.decoder_valid) begin
                    sel_cnt_d = {SEL_W{1'b0}};
                    if (rw_q == RW_WRITE) begin
                        state_d = ST_WDATA;
                    end else begin
                        addr_vld_d = 1'b1;
                        state_d    = ST_RWAIT;
                    end
                end else if (sel_cnt_q == SEL_LAST) begin
                    sel_cnt_d = {SEL_W{1'b0}};
                    state_d   = ST_IDLE;
                end else begin
                    sel_cnt_d = sel_cnt_q + SEL_W'(1);
                end
            end
            ST_WDATA: begin
                if (des_start_s) begin
                    state_d = des_done_s ? ST_SEL : ST_ADDR;
                end else if (des_done_s) begin
                    data_d     = des_data_s[DATA_WIDTH-1:0];
                    addr_vld_d = 1'b1;
                    data_vld_d = 1'b1;
                    state_d    = ST_WACK;
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_WACK: begin
                state_d = target_ack ? ST_ACK : ST_WACK;
            end
            ST_RWAIT: begin
                if (target_data_out_valid) begin
                    dout_d     = target_data_out[0];
                    dout_vld_d = 1'b1;
                    rdata_d    = target_data_out >> 1'b1;
                    bit_cnt_d  = BC_W'(1);
                    state_d    = ST_RSEND;
                end else begin
                    state_d = ST_RWAIT;
                end
            end
            ST_RSEND: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = {BC_W{1'b0}};
                    state_d   = ST_ACK;
                end else begin
                    dout_d     = rdata_q[0];
                    dout_vld_d = 1'b1;
                    rdata_d    = rdata_q >> 1'b1;
                    bit_cnt_d  = bit_cnt_q + BC_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ack_d   = (state_d == ST_ACK);
        ready_d = target_ready && (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_cnt_q  <= {SEL_W{1'b0}};
            rw_q       <= 1'b0;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            data_q     <= {DATA_WIDTH{1'b0}};
            addr_vld_q <= 1'b0;
            data_vld_q <= 1'b0;
            rdata_q    <= {DATA_WIDTH{1'b0}};
            bit_cnt_q  <= {BC_W{1'b0}};
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_cnt_q  <= sel_cnt_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            addr_vld_q <= addr_vld_d;
            data_vld_q <= data_vld_d;
            rdata_q    <= rdata_d;
            bit_cnt_q  <= bit_cnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            ack_q      <= ack_d;
            ready_q    <= ready_d;
        end
    end

    assign target_addr_in         = addr_q;
    assign target_addr_in_valid   = addr_vld_q;
    assign target_data_in         = data_q;
    assign target_data_in_valid   = data_vld_q;
    assign target_rw              = rw_q;
    assign bus.bus_data_out       = dout_q;
    assign bus.bus_data_out_valid = dout_vld_q;
    assign bus.bus_target_ready   = ready_q;
    assign bus.bus_target_rw      = rw_q;
    assign bus.bus_target_ack     = ack_q;

endmodule

// File: tb/tb_target_port.sv
// Directed bench for target_port: write, read, decode miss, gapped stream,
// restart and reset during read serialization.
module tb_target_port;
    import serial_bus_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    target_port_if bus_if();

    logic [AW-1:0] target_addr_in;
    logic          target_addr_in_valid;
    logic [DW-1:0] target_data_in;
    logic          target_data_in_valid;
    logic          target_rw;
    logic [DW-1:0] target_data_out;
    logic          target_data_out_valid;
    logic          target_ack;
    logic          target_ready;

    target_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_TIMEOUT(4)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .bus                   (bus_if),
        .target_addr_in        (target_addr_in),
        .target_addr_in_valid  (target_addr_in_valid),
        .target_data_in        (target_data_in),
        .target_data_in_valid  (target_data_in_valid),
        .target_rw             (target_rw),
        .target_data_out       (target_data_out),
        .target_data_out_valid (target_data_out_valid),
        .target_ack            (target_ack),
        .target_ready          (target_ready)
    );

    int n_checks   = 0;
    int n_pass     = 0;
    int strobe_cnt = 0;
    int ack_cnt    = 0;

    logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Count core strobes and bus acks while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            if (target_addr_in_valid) strobe_cnt <= strobe_cnt + 1;
            if (bus_if.bus_target_ack) ack_cnt <= ack_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic b, input logic m, input logic rw);
        @(negedge clk);
        bus_if.bus_data_in_valid = v;
        bus_if.bus_data_in       = b;
        bus_if.bus_mode          = m;
        bus_if.bus_rw            = rw;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, MODE_DATA, 1'b0);
    endtask

    task automatic send_addr(input logic [AW-1:0] a, input logic rw, input bit gap);
        for (int i = 0; i < AW; i++) begin
            drive(1'b1, a[i], MODE_ADDR, rw);
            if (gap && (i % 3 == 2)) begin
                idle();
                idle();
            end
        end
    endtask

    task automatic send_data(input logic [DW-1:0] d, input bit gap);
        for (int i = 0; i < DW; i++) begin
            drive(1'b1, d[i], MODE_DATA, 1'b1);
            if (gap && (i % 3 == 2)) begin
                idle();
                idle();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_if.bus_data_in       = 1'b0;
        bus_if.bus_data_in_valid = 1'b0;
        bus_if.bus_mode          = 1'b0;
        bus_if.bus_rw            = 1'b0;
        bus_if.decoder_valid     = 1'b0;
        target_data_out          = 8'h00;
        target_data_out_valid    = 1'b0;
        target_ack               = 1'b0;
        target_ready             = 1'b1;

        #1 rst_n = 1'b0;
        #1;
        check("rst_addr",       32'(target_addr_in), 32'h0);
        check("rst_addr_valid", 32'(target_addr_in_valid), 32'h0);
        check("rst_data",       32'(target_data_in), 32'h0);
        check("rst_rw",         32'(bus_if.bus_target_rw), 32'h0);
        check("rst_ready",      32'(bus_if.bus_target_ready), 32'h0);
        check("rst_dout_valid", 32'(bus_if.bus_data_out_valid), 32'h0);
        check("rst_ack",        32'(bus_if.bus_target_ack), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_ready", 32'(bus_if.bus_target_ready), 32'h1);

        // Plain write 400A / 5C, core acks 3 cycles after the strobe.
        bus_if.decoder_valid = 1'b1;
        send_addr(16'h400A, RW_WRITE, 1'b0);
        idle();
        send_data(8'h5C, 1'b0);
        idle();
        check("wr_addr_valid", 32'(target_addr_in_valid), 32'h1);
        check("wr_data_valid", 32'(target_data_in_valid), 32'h1);
        check("wr_addr",       32'(target_addr_in), 32'h400A);
        check("wr_data",       32'(target_data_in), 32'h5C);
        check("wr_target_rw",  32'(target_rw), 32'h1);
        check("wr_busy_ready", 32'(bus_if.bus_target_ready), 32'h0);
        tick();
        check("wr_strobe_1cyc", 32'(target_addr_in_valid), 32'h0);
        tick();
        tick();
        target_ack = 1'b1;
        tick();
        target_ack = 1'b0;
        check("wr_ack",    32'(bus_if.bus_target_ack), 32'h1);
        check("wr_ack_rw", 32'(bus_if.bus_target_rw), 32'h1);
        tick();
        check("wr_ack_once",  32'(bus_if.bus_target_ack), 32'h0);
        check("wr_ready_back", 32'(bus_if.bus_target_ready), 32'h1);
        #1;
        check("wr_strobe_cnt", 32'(strobe_cnt), 32'd1);
        check("wr_ack_cnt",    32'(ack_cnt), 32'd1);

        // Read 400A, core returns A5 four cycles after the request strobe.
        send_addr(16'h400A, RW_READ, 1'b0);
        idle();
        check("rd_no_early_strobe", 32'(target_addr_in_valid), 32'h0);
        idle();
        check("rd_strobe",     32'(target_addr_in_valid), 32'h1);
        check("rd_addr",       32'(target_addr_in), 32'h400A);
        check("rd_target_rw",  32'(target_rw), 32'h0);
        check("rd_no_wstrobe", 32'(target_data_in_valid), 32'h0);
        tick();
        tick();
        tick();
        target_data_out       = 8'hA5;
        target_data_out_valid = 1'b1;
        tick();
        target_data_out_valid = 1'b0;
        for (int i = 0; i < DW; i++) begin
            check($sformatf("rd_bit%0d", i),
                  32'({bus_if.bus_data_out_valid, bus_if.bus_data_out}),
                  32'({1'b1, exp_bits[i]}));
            tick();
        end
        check("rd_valid_end", 32'(bus_if.bus_data_out_valid), 32'h0);
        check("rd_ack",       32'(bus_if.bus_target_ack), 32'h1);
        check("rd_ack_rw",    32'(bus_if.bus_target_rw), 32'h0);
        tick();
        #1;
        check("rd_ack_cnt", 32'(ack_cnt), 32'd2);

        // Decode miss: full address, decoder never selects.
        bus_if.decoder_valid = 1'b0;
        send_addr(16'h1234, RW_WRITE, 1'b0);
        idle();
        idle();
        idle();
        idle();
        check("miss_busy", 32'(bus_if.bus_target_ready), 32'h0);
        idle();
        check("miss_idle", 32'(bus_if.bus_target_ready), 32'h1);
        tick();
        tick();
        #1;
        check("miss_strobe_cnt", 32'(strobe_cnt), 32'd2);
        check("miss_ack_cnt",    32'(ack_cnt), 32'd2);

        // Core strobes while idle must be ignored.
        target_ack            = 1'b1;
        target_data_out_valid = 1'b1;
        tick();
        target_ack            = 1'b0;
        target_data_out_valid = 1'b0;
        check("stray_ack",  32'(bus_if.bus_target_ack), 32'h0);
        check("stray_dout", 32'(bus_if.bus_data_out_valid), 32'h0);
        tick();
        check("stray_ready", 32'(bus_if.bus_target_ready), 32'h1);

        // Gapped write: same result as the ungapped case.
        bus_if.decoder_valid = 1'b1;
        send_addr(16'h400A, RW_WRITE, 1'b1);
        idle();
        send_data(8'h5C, 1'b1);
        idle();
        check("gap_strobe", 32'(target_addr_in_valid), 32'h1);
        check("gap_addr",   32'(target_addr_in), 32'h400A);
        check("gap_data",   32'(target_data_in), 32'h5C);
        target_ack = 1'b1;
        tick();
        target_ack = 1'b0;
        check("gap_ack", 32'(bus_if.bus_target_ack), 32'h1);

        // Restart: address bit after 3 data bits, then a full write 4001 / 11.
        send_addr(16'h7777, RW_WRITE, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, MODE_DATA, RW_WRITE);
        send_addr(16'h4001, RW_WRITE, 1'b0);
        idle();
        send_data(8'h11, 1'b0);
        idle();
        check("rs_strobe", 32'(target_addr_in_valid), 32'h1);
        check("rs_addr",   32'(target_addr_in), 32'h4001);
        check("rs_data",   32'(target_data_in), 32'h11);
        target_ack = 1'b1;
        tick();
        target_ack = 1'b0;
        check("rs_ack", 32'(bus_if.bus_target_ack), 32'h1);
        tick();
        #1;
        check("rs_strobe_cnt", 32'(strobe_cnt), 32'd4);
        check("rs_ack_cnt",    32'(ack_cnt), 32'd4);

        // Reset while serializing read data.
        send_addr(16'h400A, RW_READ, 1'b0);
        idle();
        idle();
        tick();
        target_data_out       = 8'h3C;
        target_data_out_valid = 1'b1;
        tick();
        target_data_out_valid = 1'b0;
        tick();
        tick();
        check("rsend_active", 32'(bus_if.bus_data_out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mrst_dout_valid", 32'(bus_if.bus_data_out_valid), 32'h0);
        check("mrst_addr",       32'(target_addr_in), 32'h0);
        check("mrst_rw",         32'(bus_if.bus_target_rw), 32'h0);
        check("mrst_ack",        32'(bus_if.bus_target_ack), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        #1;
        check("mrst_no_ack",      32'(ack_cnt), 32'd4);
        check("mrst_dout_quiet",  32'(bus_if.bus_data_out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/target_port.md
# target_port

Non-split serial-bus target port. It deserializes the address and write-data stream driven by the initiator port, and presents a parallel request to a fixed-latency target core. On reads, it serializes the returned byte back onto the bus. It sits between the shared serial bus (initiator port, address decoder, arbiter) and a non-split target core, as the counterpart of the split target port.

## Interface
- `ADDR_WIDTH`, default 16: serial address length in bits.
- `DATA_WIDTH`, default 8: serial data length in bits.
- `SEL_TIMEOUT`, default 4: cycles to wait for `decoder_valid` after the last address bit.
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `bus_data_in`  in  1  serial bit from the initiator.
- `bus_data_in_valid`  in  1  qualifies `bus_data_in`.
- `bus_mode`  in  1  1 = address phase, 0 = data phase.
- `bus_rw`  in  1  1 = write, 0 = read; sampled with the last address bit.
- `decoder_valid`  in  1  this target is selected by the address decoder.
- `target_addr_in`  out  `ADDR_WIDTH`  captured address.
- `target_addr_in_valid`  out  1  one-cycle request strobe to the core.
- `target_data_in`  out  `DATA_WIDTH`  captured write data.
- `target_data_in_valid`  out  1  one-cycle write-data strobe.
- `target_rw`  out  1  latched direction.
- `target_data_out`  in  `DATA_WIDTH`  read data from the core.
- `target_data_out_valid`  in  1  read data strobe.
- `target_ack`  in  1  write-complete pulse from the core.
- `target_ready`  in  1  core can accept a request.
- `bus_data_out`  out  1  serial read data, LSB first.
- `bus_data_out_valid`  out  1  qualifies `bus_data_out`.
- `bus_target_ready`  out  1  port idle and core ready.
- `bus_target_rw`  out  1  direction of the current or last transaction.
- `bus_target_ack`  out  1  one-cycle transaction-complete pulse.

## Operation
- **Bit counting:** bits are counted only on cycles where `bus_data_in_valid` = 1. Gaps of any length are tolerated. All streams are LSB first.
- **States:** IDLE, ADDR, SEL, WDATA, WACK, RWAIT, RSEND, ACK.
- **IDLE:**
  - A valid bit with `bus_mode` = 1 stores address bit 0, sets the counter to 1, and moves to ADDR.
  - A valid bit with `bus_mode` = 0 is ignored.
- **ADDR:**
  - Shifts in address bits.
  - On bit `ADDR_WIDTH`-1, latches `bus_rw` into `target_rw`/`bus_target_rw` and moves to SEL.
- **SEL:**
  - If `decoder_valid` = 1 and this is a write, moves to WDATA.
  - If `decoder_valid` = 1 and this is a read, pulses `target_addr_in_valid` and moves to RWAIT.
  - If `decoder_valid` stays 0 for `SEL_TIMEOUT` cycles, returns to IDLE silently.
- **WDATA:**
  - Shifts in `DATA_WIDTH` bits with `bus_mode` = 0.
  - After the last bit, pulses `target_addr_in_valid` and `target_data_in_valid` together for 1 cycle, then moves to WACK.
- **WACK:** on `target_ack`, moves to ACK.
- **RWAIT:** on `target_data_out_valid`, latches `target_data_out` and moves to RSEND.
- **RSEND:** drives `bus_data_out_valid` = 1 for exactly `DATA_WIDTH` consecutive cycles, then moves to ACK.
- **ACK:** pulses `bus_target_ack` for 1 cycle, then returns to IDLE.
- **`bus_target_ready`:** registered copy of `target_ready`, forced to 0 outside IDLE.
- **Restart:** a valid bit with `bus_mode` = 1 arriving in WDATA aborts the transaction. No strobes are issued, and address capture restarts at bit 0.
- **Core strobes out of state:** `target_ack` and `target_data_out_valid` outside WACK/RWAIT are ignored.

## Timing
- **Reset values:** state IDLE, counters 0, and every output 0, including `target_addr_in` and `target_data_in`.
- **Reset mid-transaction:** returns to IDLE immediately with no strobe or ack.
- **Write latency:** last data bit at cycle N gives the core strobes at N+1. `target_ack` at cycle M gives `bus_target_ack` at M+1.
- **Read latency:** last address bit at cycle N gives `target_addr_in_valid` at N+2 at the earliest, if `decoder_valid` is already high at N+1. `target_data_out_valid` at cycle M gives serial bits at M+1..M+8 and `bus_target_ack` at M+9.
- **Exactly one** `bus_target_ack` per completed transaction. `bus_target_rw` holds its value until the next ADDR completes.
- **Simultaneous events:** a valid bit in the same cycle as the ACK pulse is ignored. The initiator must not start before seeing the ack.

## Structure
- **Shared package:** `serial_bus_pkg` holds `ADDR_WIDTH`/`DATA_WIDTH` defaults, the `bus_mode` encodings (MODE_ADDR = 1, MODE_DATA = 0), the rw encodings, and the `target_port_state_t` enum.
- **Sub-module:** one sub-module, `serial_deserializer`: a parameterized width, LSB-first shift register with a bit counter and a done pulse. It is instantiated once and reused for both the address and data phases.
- **Top level:** FSM, serializer, and output registers stay in the top module.

## Test plan
- **Write:** addr 16'h400A, rw = 1, data 8'h5C, `decoder_valid` high, core acks 3 cycles later -> one strobe with addr 400A / data 5C; `bus_target_ack` = 1 with `bus_target_rw` = 1 exactly once.
- **Read:** addr 16'h400A, rw = 0, core returns 8'hA5 after 4 cycles -> `bus_data_out` bits 1,0,1,0,0,1,0,1 with valid held 8 cycles; then `bus_target_ack` with `bus_target_rw` = 0.
- **Decode miss:** full address with `decoder_valid` held 0 -> back to IDLE after `SEL_TIMEOUT`; no core strobe, no ack.
- **Gapped stream:** write with `bus_data_in_valid` dropping for 2 cycles every third bit -> same captured addr/data as the ungapped case.
- **Restart and reset:** an address bit arrives after 3 write-data bits, then a full new write of 16'h4001/8'h11 -> only 4001/11 reaches the core. Separately, reset asserted during RSEND -> all outputs 0 the next cycle and no ack.
